// File: rtl/br_rs_sched.sv
// rtl/br_rs_sched.sv - branch reservation station with oldest-ready issue select
package br_rs_pkg;

  // ALU operation encodings; only BEQ..JMP reach this station
  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    BEQ    = 3'd1,
    BNE    = 3'd2,
    BLT    = 3'd3,
    BGE    = 3'd4,
    BLTU   = 3'd5,
    BGEU   = 3'd6,
    JMP    = 3'd7
  } alu_op_t;

  // Producer tags on the CDB; NO_VAL marks "no producer" and never matches
  typedef enum logic [2:0] {
    NO_VAL = 3'd0,
    ALU_0  = 3'd1,
    ALU_1  = 3'd2,
    LSU_0  = 3'd3,
    MUL_0  = 3'd4,
    BR_0   = 3'd5
  } rs_tag_t;

endpackage

module br_rs_sched
  import br_rs_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DWIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       disp_valid_i,
  output logic                       disp_ready_o,
  input  alu_op_t                    disp_oper_i,
  input  logic [DWIDTH-1:0]          disp_pc_i,
  input  logic [11:0]                disp_imm12_i,
  input  logic                       disp_rs1_rdy_i,
  input  logic                       disp_rs2_rdy_i,
  input  logic [DWIDTH-1:0]          disp_rs1_val_i,
  input  logic [DWIDTH-1:0]          disp_rs2_val_i,
  input  rs_tag_t                    disp_rs1_tag_i,
  input  rs_tag_t                    disp_rs2_tag_i,
  input  logic                       cdb_valid_i,
  input  rs_tag_t                    cdb_tag_i,
  input  logic [DWIDTH-1:0]          cdb_val_i,
  output logic                       iss_valid_o,
  input  logic                       iss_ready_i,
  output alu_op_t                    iss_oper_o,
  output logic [DWIDTH-1:0]          iss_pc_o,
  output logic [11:0]                iss_imm12_o,
  output logic [DWIDTH-1:0]          iss_rs1_val_o,
  output logic [DWIDTH-1:0]          iss_rs2_val_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic              rdy;
    rs_tag_t           tag;
    logic [DWIDTH-1:0] val;
  } opnd_t;

  typedef struct packed {
    logic              vld;
    alu_op_t           oper;
    logic [DWIDTH-1:0] pc;
    logic [11:0]       imm;
    opnd_t             rs1;
    opnd_t             rs2;
  } ent_t;

  // Pending operand snoops the CDB; ready operands and NO_VAL tags are left alone
  function automatic opnd_t snoop(input opnd_t o, input logic cv, input rs_tag_t ct,
                                  input logic [DWIDTH-1:0] cval);
    opnd_t r;
    r = o;
    if (!o.rdy && cv && (o.tag == ct) && (o.tag != NO_VAL)) begin
      r.rdy = 1'b1;
      r.val = cval;
    end
    return r;
  endfunction

  ent_t          ent_q [DEPTH];
  ent_t          woke  [DEPTH];
  ent_t          ent_d [DEPTH];
  ent_t          new_ent;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] wr_idx;
  logic [DEPTH-1:0] rdy_vec;
  logic [IW-1:0] sel_idx;
  logic          sel_found;
  logic          iss_fire;
  logic          disp_fire;

  // Readiness comes from registered state only, so wakeups take effect a cycle later
  always_comb begin
    rdy_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = ent_q[i].vld & ent_q[i].rs1.rdy & ent_q[i].rs2.rdy;
    end
  end

  // Lowest index is oldest, so the first ready slot wins
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && rdy_vec[i]) begin
        sel_idx   = IW'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign disp_ready_o = (count_q < CW'(DEPTH));
  assign iss_valid_o  = sel_found;
  assign iss_fire     = sel_found & iss_ready_i & ~flush_i;
  assign disp_fire    = disp_valid_i & disp_ready_o & ~flush_i;
  assign count_o      = count_q;

  // Issue payload is forced to zero whenever nothing is selectable
  always_comb begin
    iss_oper_o    = OP_NOP;
    iss_pc_o      = '0;
    iss_imm12_o   = '0;
    iss_rs1_val_o = '0;
    iss_rs2_val_o = '0;
    if (sel_found) begin
      iss_oper_o    = ent_q[sel_idx].oper;
      iss_pc_o      = ent_q[sel_idx].pc;
      iss_imm12_o   = ent_q[sel_idx].imm;
      iss_rs1_val_o = ent_q[sel_idx].rs1.val;
      iss_rs2_val_o = ent_q[sel_idx].rs2.val;
    end
  end

  // Incoming entry, with a same-cycle CDB match folded straight in
  always_comb begin
    new_ent      = '0;
    new_ent.vld  = 1'b1;
    new_ent.oper = disp_oper_i;
    new_ent.pc   = disp_pc_i;
    new_ent.imm  = disp_imm12_i;
    new_ent.rs1  = snoop('{rdy: disp_rs1_rdy_i, tag: disp_rs1_tag_i, val: disp_rs1_val_i},
                         cdb_valid_i, cdb_tag_i, cdb_val_i);
    new_ent.rs2  = snoop('{rdy: disp_rs2_rdy_i, tag: disp_rs2_tag_i, val: disp_rs2_val_i},
                         cdb_valid_i, cdb_tag_i, cdb_val_i);
  end

  // Wakeup, then collapse above the issued slot, then append at the new tail
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i]     = ent_q[i];
      woke[i].rs1 = snoop(ent_q[i].rs1, cdb_valid_i, cdb_tag_i, cdb_val_i);
      woke[i].rs2 = snoop(ent_q[i].rs2, cdb_valid_i, cdb_tag_i, cdb_val_i);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (iss_fire && (i >= int'(sel_idx))) begin
        ent_d[i] = woke[i+1];
      end else begin
        ent_d[i] = woke[i];
      end
    end
    // The top slot always empties on issue since the selected index is at or below it
    ent_d[DEPTH-1] = iss_fire ? '0 : woke[DEPTH-1];
    wr_idx = count_q - CW'(iss_fire);
    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          ent_d[i] = new_ent;
        end
      end
    end
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].vld = 1'b0;
      end
    end
  end

  // Occupancy tracks dispatch and issue; flush empties the station
  always_comb begin
    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(disp_fire) - CW'(iss_fire);
    end
  end

  // Entry and count registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule
